// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the core memory stage and a
// word-indexed data memory. It accepts one byte-addressed RISC-V load or store
// (LB/LH/LW/LBU/LHU/SB/SH/SW) and turns it into word accesses. Sub-word stores
// are done as read-modify-write. Loads return sign- or zero-extended data.
// Faulting requests complete without touching memory.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   req             request strobe, sampled only in IDLE
//   is_store        1 = store, 0 = load (captured with req)
//   funct3          RISC-V width/sign code (captured with req)
//   addr            byte address (captured with req)
//   store_data      store source rs2 (captured with req)
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle completion pulse
//   load_data       extended load result, held until the next accepted load
//   err, err_code   fault flag and code (01 misaligned, 10 range, 11 illegal),
//                   valid with done
//   MemRead         memory read enable
//   MemWrite        memory write enable
//   mem_address     word index {2'b00, addr_q[31:2]}
//   mem_write_data  word to write
//   read_data       combinational memory read word
//
// Handshake: req is honoured only on a posedge where the block is in IDLE.
// A req seen in any other state is dropped, never queued. Every accepted
// request produces exactly one done pulse unless reset intervenes.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] read_data
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] addr_q,       addr_d;
    logic [2:0]  funct3_q,     funct3_d;
    logic        is_store_q,   is_store_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] rdata_q,      rdata_d;
    logic [31:0] load_data_q,  load_data_d;
    logic        err_q,        err_d;
    logic [1:0]  err_code_q,   err_code_d;

    // Fault classification of the incoming request.
    logic f_illegal, f_misaligned, f_range;

    always_comb begin
        f_illegal = 1'b0;
        if (is_store) begin
            f_illegal = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end else begin
            f_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        // funct3[1:0] encodes the access size for every legal code.
        f_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        f_range      = ({2'b00, addr[31:2]} >= MEM_WORDS_W);
    end

    // Load extraction straight from the memory word so load_data can update
    // on the RD->DONE edge.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = read_data[7:0];
            2'd1:    ld_byte = read_data[15:8];
            2'd2:    ld_byte = read_data[23:16];
            default: ld_byte = read_data[31:24];
        endcase
        ld_half = addr_q[1] ? read_data[31:16] : read_data[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = read_data;
        endcase
    end

    // Store merge: the word read in RD with the addressed lane replaced.
    logic [31:0] wr_word;

    always_comb begin
        wr_word = rdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    wr_word[7:0]   = store_data_q[7:0];
                    2'd1:    wr_word[15:8]  = store_data_q[7:0];
                    2'd2:    wr_word[23:16] = store_data_q[7:0];
                    default: wr_word[31:24] = store_data_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) wr_word[31:16] = store_data_q[15:0];
                else           wr_word[15:0]  = store_data_q[15:0];
            end
            default: wr_word = store_data_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        store_data_d = store_data_q;
        rdata_d      = rdata_q;
        load_data_d  = load_data_q;
        err_d        = err_q;
        err_code_d   = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d       = addr;
                    funct3_d     = funct3;
                    is_store_d   = is_store;
                    store_data_d = store_data;
                    err_d        = 1'b1;
                    state_d      = S_DONE;
                    if (f_illegal) begin
                        err_code_d = 2'b11;
                    end else if (f_misaligned) begin
                        err_code_d = 2'b01;
                    end else if (f_range) begin
                        err_code_d = 2'b10;
                    end else begin
                        err_d      = 1'b0;
                        err_code_d = 2'b00;
                        state_d    = (is_store && (funct3 == 3'b010)) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                rdata_d = read_data;
                if (is_store_q) begin
                    state_d = S_WR;
                end else begin
                    load_data_d = ld_ext;
                    state_d     = S_DONE;
                end
            end
            S_WR: begin
                state_d = S_DONE;
            end
            default: begin
                // DONE: the error flags live exactly one cycle.
                err_d      = 1'b0;
                err_code_d = 2'b00;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            store_data_q <= '0;
            rdata_q      <= '0;
            load_data_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            store_data_q <= store_data_d;
            rdata_q      <= rdata_d;
            load_data_q  <= load_data_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // Outputs are decoded from registered state. The memory enables are also
    // gated by reset so a reset landing in RD/WR never lets a write through.
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign load_data      = load_data_q;
    assign MemRead        = (state_q == S_RD) && !reset;
    assign MemWrite       = (state_q == S_WR) && !reset;
    assign mem_address    = {2'b00, addr_q[31:2]};
    assign mem_write_data = (state_q == S_WR) ? wr_word : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err;
    logic [1:0]  err_code;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] read_data;

    lsu_mem_ctrl #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data), .err(err),
        .err_code(err_code), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .read_data(read_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model
    logic [31:0] mem [0:1023];
    assign read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;
    always @(posedge clk) begin
        if (MemWrite && (mem_address < 32'd1024)) mem[mem_address[9:0]] <= mem_write_data;
    end

    // scoreboard counters
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [3:0]  lat;
        logic [1:0]  code;
        logic [31:0] ld;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    // Issue one request starting at a negedge; returns at the negedge of the
    // following IDLE cycle.
    task automatic do_vec(input string tag, input vec_t v);
        int cyc;
        logic saw_rd, saw_wr, bad_both, bad_busy, bad_err;
        logic [31:0] wr_addr;
        logic fault, exp_rd, exp_wr;
        fault  = (v.code != 2'b00);
        exp_wr = !fault && v.st;
        exp_rd = !fault && !(v.st && (v.f3 == 3'b010));
        saw_rd = 0; saw_wr = 0; bad_both = 0; bad_busy = 0; bad_err = 0;
        wr_addr = 32'hFFFF_FFFF;
        is_store = v.st; funct3 = v.f3; addr = v.addr; store_data = v.sd; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        while (!done && cyc <= 8) begin
            if (MemRead) saw_rd = 1;
            if (MemWrite) begin saw_wr = 1; wr_addr = mem_address; end
            if (MemRead && MemWrite) bad_both = 1;
            if (!busy) bad_busy = 1;
            if (err || err_code != 2'b00) bad_err = 1;
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = 99;
        check({tag, "_latency"}, 32'(cyc), 32'(v.lat));
        check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h1);
        check({tag, "_err"}, {31'h0, err}, {31'h0, fault});
        check({tag, "_err_code"}, {30'h0, err_code}, {30'h0, v.code});
        check({tag, "_memread_seen"}, {31'h0, saw_rd}, {31'h0, exp_rd});
        check({tag, "_memwrite_seen"}, {31'h0, saw_wr}, {31'h0, exp_wr});
        check({tag, "_busy_err_both_glitch"}, {29'h0, bad_both, bad_busy, bad_err}, 32'h0);
        @(negedge clk);
        check({tag, "_load_data"}, load_data, v.ld);
        check({tag, "_idle_after"}, {30'h0, busy, done}, 32'h0);
        if (exp_wr) begin
            check({tag, "_wr_index"}, wr_addr, {2'b00, v.addr[31:2]});
            check({tag, "_mem_word"}, mem[v.addr[11:2]], v.word);
        end
    endtask

    initial begin
        // st, f3, addr, sd, lat, code, ld, word
        vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 4'd2, 2'b00, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        4'd2, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 3'b010, 32'h10,   32'h11223344, 4'd2, 2'b00, 32'hDEADBEEF, 32'h11223344};
        vecs[3]  = '{1'b1, 3'b000, 32'h12,   32'h123456AA, 4'd3, 2'b00, 32'hDEADBEEF, 32'h11AA3344};
        vecs[4]  = '{1'b0, 3'b000, 32'h12,   32'h0,        4'd2, 2'b00, 32'hFFFFFFAA, 32'h0};
        vecs[5]  = '{1'b0, 3'b100, 32'h12,   32'h0,        4'd2, 2'b00, 32'h000000AA, 32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h12,   32'hCAFE8001, 4'd3, 2'b00, 32'h000000AA, 32'h80013344};
        vecs[7]  = '{1'b0, 3'b001, 32'h12,   32'h0,        4'd2, 2'b00, 32'hFFFF8001, 32'h0};
        vecs[8]  = '{1'b0, 3'b101, 32'h12,   32'h0,        4'd2, 2'b00, 32'h00008001, 32'h0};
        vecs[9]  = '{1'b0, 3'b000, 32'h13,   32'h0,        4'd2, 2'b00, 32'hFFFFFF80, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h10,   32'h0,        4'd2, 2'b00, 32'h00003344, 32'h0};
        vecs[11] = '{1'b0, 3'b010, 32'h13,   32'h0,        4'd1, 2'b01, 32'h00003344, 32'h0};
        vecs[12] = '{1'b1, 3'b000, 32'h1000, 32'h77,       4'd1, 2'b10, 32'h00003344, 32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h10,   32'h0,        4'd1, 2'b11, 32'h00003344, 32'h0};
        vecs[14] = '{1'b0, 3'b110, 32'h13,   32'h0,        4'd1, 2'b11, 32'h00003344, 32'h0};
        vecs[15] = '{1'b1, 3'b100, 32'h10,   32'h5,        4'd1, 2'b11, 32'h00003344, 32'h0};
        vecs[16] = '{1'b0, 3'b010, 32'h1001, 32'h0,        4'd1, 2'b01, 32'h00003344, 32'h0};
        vecs[17] = '{1'b0, 3'b001, 32'h11,   32'h0,        4'd1, 2'b01, 32'h00003344, 32'h0};
        vecs[18] = '{1'b1, 3'b010, 32'hFFC,  32'h12345678, 4'd2, 2'b00, 32'h00003344, 32'h12345678};
        vecs[19] = '{1'b0, 3'b010, 32'hFFC,  32'h0,        4'd2, 2'b00, 32'h12345678, 32'h0};
        vecs[20] = '{1'b1, 3'b000, 32'h11,   32'h55,       4'd3, 2'b00, 32'h12345678, 32'h80015544};
        vecs[21] = '{1'b0, 3'b100, 32'h11,   32'h0,        4'd2, 2'b00, 32'h00000055, 32'h0};
        vecs[22] = '{1'b0, 3'b010, 32'h10,   32'h0,        4'd2, 2'b00, 32'h80015544, 32'h0};
        vecs[23] = '{1'b1, 3'b001, 32'h10,   32'hBEEF,     4'd3, 2'b00, 32'h80015544, 32'h8001BEEF};
        vecs[24] = '{1'b0, 3'b001, 32'h10,   32'h0,        4'd2, 2'b00, 32'hFFFFBEEF, 32'h0};
        vecs[25] = '{1'b0, 3'b000, 32'h1000, 32'h0,        4'd1, 2'b10, 32'hFFFFBEEF, 32'h0};

        reset = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_outputs",
              {busy, done, err, err_code, MemRead, MemWrite, 25'h0},
              32'h0);
        check("reset_load_data", load_data, 32'h0);
        check("reset_mem_address", mem_address, 32'h0);
        check("reset_mem_write_data", mem_write_data, 32'h0);

        // first vector goes out in the first post-reset cycle
        for (int i = 0; i < NV; i++) do_vec($sformatf("v%0d", i), vecs[i]);

        // reset landing in the WR cycle of an SB aborts the write
        do_vec("rst_pre_sw", '{1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 4'd2, 2'b00, 32'hFFFFBEEF, 32'hA5A5A5A5});
        is_store = 1'b1; funct3 = 3'b000; addr = 32'h20; store_data = 32'h11; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rst_rd_memread", {31'h0, MemRead}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_memwrite_before", {31'h0, MemWrite}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_wr_memwrite_gated", {31'h0, MemWrite}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_idle_after", {30'h0, busy, done}, 32'h0);
        check("rst_mem_unchanged", mem[8], 32'hA5A5A5A5);
        @(negedge clk);
        check("rst_no_late_done", {30'h0, busy, done}, 32'h0);
        do_vec("rst_post_lw", '{1'b0, 3'b010, 32'h20, 32'h0, 4'd2, 2'b00, 32'hA5A5A5A5, 32'h0});

        // req held high across three LW requests
        begin
            int n_done;
            logic exp_done, exp_busy;
            n_done = 0;
            is_store = 1'b0; funct3 = 3'b010; addr = 32'h10; store_data = 32'h0; req = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k == 7) req = 1'b0;
                exp_done = (k == 2) || (k == 5) || (k == 8);
                exp_busy = (k == 1) || (k == 2) || (k == 4) || (k == 5) || (k == 7) || (k == 8);
                if (done) n_done++;
                check($sformatf("held_k%0d_done_busy", k), {30'h0, done, busy}, {30'h0, exp_done, exp_busy});
                check($sformatf("held_k%0d_no_write", k), {31'h0, MemWrite}, 32'h0);
            end
            check("held_done_count", 32'(n_done), 32'd3);
            check("held_load_data", load_data, 32'h8001BEEF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
